// File: rtl/signed_or_unsigned_mul_seq_pkg.sv
// Shared types and helpers for the iterative signed/unsigned multiplier.
// Operand widths up to 32 bits are supported: result width 2n must fit MAX_W.
package mul_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Step counter width: enough to count 0..w-1, never narrower than 1 bit.
    function automatic int ctr_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    // Conditional two's-complement negation at MAX_W bits. Callers zero-extend
    // and truncate; the low bits of the negation are correct at any width.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] value,
                                                  input logic             en);
        return en ? (~value + MAX_W'(1)) : value;
    endfunction

endpackage

// File: rtl/signed_or_unsigned_mul_seq_abs.sv
// Operand-to-magnitude conversion: negates a negative two's-complement value
// when en is set. -2^(n-1) maps to 2^(n-1), which still fits n unsigned bits.
module mul_abs
    import mul_pkg::*;
#(
    parameter int n = 8
) (
    input  logic [n-1:0] value,
    input  logic         en,
    output logic [n-1:0] mag
);

    // Negate only signed operands whose sign bit is set.
    always_comb begin
        mag = n'(cond_neg(MAX_W'(value), en & value[n-1]));
    end

endmodule

// File: rtl/signed_or_unsigned_mul_seq.sv
// Iterative shift-add multiplier with valid/ready handshakes on both sides.
// Multiplies magnitudes unsigned over n steps, then applies the result sign.
module signed_or_unsigned_mul_seq
    import mul_pkg::*;
#(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           arg_vld,
    output logic           arg_rdy,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    input  logic           signed_mul,
    output logic           res_vld,
    input  logic           res_rdy,
    output logic [2*n-1:0] res
);

    localparam int CW = ctr_width(n);

    mul_state_t      state;
    mul_state_t      state_next;

    logic [n-1:0]    a_mag;
    logic [n-1:0]    b_mag;
    logic [2*n-1:0]  mcand;
    logic [n-1:0]    mplier;
    logic [2*n-1:0]  acc;
    logic [2*n-1:0]  acc_sum;
    logic [CW-1:0]   cnt;
    logic            neg;
    logic            accept;
    logic            last_step;

    mul_abs #(.n(n)) u_abs_a (.value(a), .en(signed_mul), .mag(a_mag));
    mul_abs #(.n(n)) u_abs_b (.value(b), .en(signed_mul), .mag(b_mag));

    // Partial-product add for the current step and handshake decodes.
    always_comb begin
        acc_sum   = acc + (mplier[0] ? mcand : '0);
        accept    = arg_vld && arg_rdy;
        last_step = (cnt == CW'(n - 1));
    end

    // State register; reset wins over any handshake on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned
        // (which would infer a latch).
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = BUSY;
            BUSY:    if (last_step) state_next = DONE;
            DONE:    if (res_rdy)   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        arg_rdy = (state == IDLE);
        res_vld = (state == DONE);
    end

    // Datapath: capture magnitudes on accept, one shift-add per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every datapath register is cleared so res reads 0 after
            // reset and an abandoned transaction leaves no residue.
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            res    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= {{n{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= signed_mul & (a[n-1] ^ b[n-1]);
                    end
                end
                BUSY: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_step) begin
                        res <= (2*n)'(cond_neg(MAX_W'(acc_sum), neg));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_or_unsigned_mul_seq.sv
// Self-checking bench: scoreboard queue of expected products, directed
// corner cases, backpressure, reset mid-operation and random traffic.
module tb_signed_or_unsigned_mul_seq;

    localparam int N  = 8;
    localparam int W  = 2 * N;
    localparam int TO = 100;

    logic         clk = 1'b0;
    logic         rst;
    logic         arg_vld;
    logic         arg_rdy;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         signed_mul;
    logic         res_vld;
    logic         res_rdy;
    logic [W-1:0] res;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q[$];

    signed_or_unsigned_mul_seq #(.n(N)) dut (
        .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy),
        .a(a), .b(b), .signed_mul(signed_mul),
        .res_vld(res_vld), .res_rdy(res_rdy), .res(res)
    );

    always #5 clk = ~clk;

    // Reference: extend each operand per mode to 2n bits, multiply, truncate.
    function automatic logic [W-1:0] ref_mul(input logic [N-1:0] x,
                                             input logic [N-1:0] y,
                                             input logic         s);
        logic [W-1:0] xe, ye;
        xe = s ? {{N{x[N-1]}}, x} : {{N{1'b0}}, x};
        ye = s ? {{N{y[N-1]}}, y} : {{N{1'b0}}, y};
        return W'(xe * ye);
    endfunction

    // Drive one transaction (inputs change and outputs sample on negedge).
    // hold: cycles of res_rdy=0 after res_vld; chk_lat: check n-step latency.
    task automatic run_txn(input logic [N-1:0] ta, input logic [N-1:0] tb,
                           input logic ts, input int hold, input bit chk_lat,
                           input string name);
        int           lat;
        int           wait_cnt;
        logic [W-1:0] held;
        logic [W-1:0] expv;
        exp_q.push_back(ref_mul(ta, tb, ts));
        a = ta; b = tb; signed_mul = ts; arg_vld = 1'b1;
        wait_cnt = 0;
        while (!arg_rdy && wait_cnt < TO) begin
            @(negedge clk);
            wait_cnt++;
        end
        vectors++;
        if (!arg_rdy) begin
            miscompares++;
            $display("FAIL %s accept_timeout arg_rdy=%0b required 1", name, arg_rdy);
            arg_vld = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(negedge clk);  // accept edge E0 has passed
        arg_vld = 1'b0;
        a = N'($urandom); b = N'($urandom); signed_mul = 1'($urandom);
        lat = 0;
        while (!res_vld && lat < TO) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (!res_vld) begin
            miscompares++;
            $display("FAIL %s result_timeout res_vld=%0b required 1", name, res_vld);
            void'(exp_q.pop_front());
            return;
        end
        if (chk_lat) begin
            vectors++;
            if (lat !== N) begin
                miscompares++;
                $display("FAIL %s latency edges=%0d required %0d", name, lat, N);
            end
        end
        held = res;
        for (int i = 0; i < hold; i++) begin
            res_rdy = 1'b0;
            arg_vld = 1'($urandom);  // must be ignored while not IDLE
            @(negedge clk);
            vectors++;
            if (res !== held || res_vld !== 1'b1 || arg_rdy !== 1'b0) begin
                miscompares++;
                $display("FAIL %s backpressure res=%h vld=%0b rdy=%0b required res=%h vld=1 rdy=0",
                         name, res, res_vld, arg_rdy, held);
            end
        end
        arg_vld = 1'b0;
        expv = exp_q.pop_front();
        vectors++;
        if (res !== expv) begin
            miscompares++;
            $display("FAIL %s product a=%h b=%h s=%0b res=%h required %h",
                     name, ta, tb, ts, res, expv);
        end
        res_rdy = 1'b1;
        @(negedge clk);  // hand-off edge
        res_rdy = 1'b0;
        vectors++;
        if (res_vld !== 1'b0 || arg_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s handoff res_vld=%0b arg_rdy=%0b required 0 1",
                     name, res_vld, arg_rdy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; arg_vld = 1'b1; res_rdy = 1'b1;
        a = 8'h12; b = 8'h34; signed_mul = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; arg_vld = 1'b0; res_rdy = 1'b0;
        vectors++;
        if (arg_rdy !== 1'b1 || res_vld !== 1'b0 || res !== '0) begin
            miscompares++;
            $display("FAIL reset arg_rdy=%0b res_vld=%0b res=%h required 1 0 0000",
                     arg_rdy, res_vld, res);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] r;
        // Hand-derived constants guard the reference model itself.
        r = ref_mul(8'd253, 8'd5, 1'b0);
        vectors++;
        if (r !== 16'h04F1) begin
            miscompares++;
            $display("FAIL model_unsigned got=%h required 04F1", r);
        end
        r = ref_mul(8'hFD, 8'd5, 1'b1);
        vectors++;
        if (r !== 16'hFFF1) begin
            miscompares++;
            $display("FAIL model_signed got=%h required FFF1", r);
        end
        run_txn(8'd253, 8'd5, 1'b0, 0, 1'b1, "unsigned_253x5");
        run_txn(8'hFD,  8'd5, 1'b1, 0, 1'b1, "signed_m3x5");
        run_txn(8'hFD,  8'd5, 1'b0, 0, 1'b0, "unsigned_FDx5");
        run_txn(8'h80,  8'h80, 1'b1, 0, 1'b0, "signed_80x80");
        run_txn(8'hFF,  8'hFF, 1'b0, 0, 1'b0, "unsigned_FFxFF");
        run_txn(8'hFF,  8'hFF, 1'b1, 0, 1'b0, "signed_FFxFF");
        run_txn(8'h00,  8'hFF, 1'b0, 0, 1'b1, "zero_x_FF");
        run_txn(8'h7F,  8'h80, 1'b1, 0, 1'b0, "signed_7Fx80");
    endtask

    task automatic test_backpressure();
        run_txn(8'd200, 8'd3, 1'b0, 5, 1'b0, "backpressure");
    endtask

    task automatic test_reset_mid_busy();
        a = 8'd9; b = 8'd9; signed_mul = 1'b0; arg_vld = 1'b1;
        @(negedge clk);  // accept edge
        arg_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;      // third edge after accept
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (res_vld !== 1'b0 || res !== '0 || arg_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_busy res_vld=%0b res=%h arg_rdy=%0b required 0 0000 1",
                     res_vld, res, arg_rdy);
        end
        run_txn(8'd7, 8'd6, 1'b0, 0, 1'b0, "after_reset_7x6");
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 1000; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            run_txn(N'($urandom), N'($urandom), 1'($urandom),
                    $urandom_range(0, 3), 1'b0, "random");
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover size=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
